// File: rtl/time_keeper_if.sv
// Time-of-day keeper handshake bundle.
// Mode/button inputs from the panel and time outputs to the display.
interface time_keeper_if;
  logic        set_mode;
  logic        inc_hour;
  logic        inc_min;
  logic [16:0] disp_time;
  logic        sec_tick;
  logic        day_wrap;

  modport master (
    output set_mode,
    output inc_hour,
    output inc_min,
    input  disp_time,
    input  sec_tick,
    input  day_wrap
  );

  modport slave (
    input  set_mode,
    input  inc_hour,
    input  inc_min,
    output disp_time,
    output sec_tick,
    output day_wrap
  );
endinterface

// File: rtl/time_keeper.sv
// Time-of-day source: one-second prescaler, hh/mm/ss counters, RUN/SET mode.
// disp_time is seconds since midnight, registered one cycle after the counters.
module time_keeper #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int RESET_TIME    = 0
) (
  input logic          clk,
  input logic          reset,
  time_keeper_if.slave tk
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [4:0]  RST_HH   = 5'(RESET_TIME / 3600);
  localparam logic [5:0]  RST_MM   = 6'((RESET_TIME % 3600) / 60);
  localparam logic [5:0]  RST_SS   = 6'(RESET_TIME % 60);
  localparam logic [16:0] RST_DISP = 17'(RESET_TIME);

  typedef enum logic {
    RUN = 1'b0,
    SET = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [PW-1:0] presc;
  logic [4:0]    hh;
  logic [5:0]    mm;
  logic [5:0]    ss;

  logic terminal;
  logic count_en;
  logic tick_en;
  logic enter_set;
  logic edit_en;
  logic ss_wrap;
  logic mm_wrap;
  logic hh_wrap;
  logic mm_carry;
  logic hh_carry;

  logic [16:0] hh_x;
  logic [16:0] mm_x;
  logic [16:0] hh_secs;
  logic [16:0] mm_secs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: if (tk.set_mode)  state_nxt = SET;
      SET: if (!tk.set_mode) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // The mode-change edge itself never counts a tick.
  always_comb begin
    count_en  = 1'b0;
    enter_set = 1'b0;
    edit_en   = 1'b0;
    unique case (state)
      RUN: begin
        count_en  = !tk.set_mode;
        enter_set = tk.set_mode;
      end
      SET: edit_en = 1'b1;
      default: ;
    endcase
  end

  assign terminal = presc == PRESC_MAX;
  assign tick_en  = count_en && terminal;
  assign ss_wrap  = ss == 6'd59;
  assign mm_wrap  = mm == 6'd59;
  assign hh_wrap  = hh == 5'd23;
  assign mm_carry = tick_en && ss_wrap;
  assign hh_carry = mm_carry && mm_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     presc <= '0;
    else if (count_en && !terminal) presc <= presc + 1'b1;
    else                           presc <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          ss <= RST_SS;
    else if (enter_set) ss <= '0;
    else if (tick_en)   ss <= ss_wrap ? 6'd0 : ss + 6'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mm <= RST_MM;
    else if (mm_carry || (edit_en && tk.inc_min))
      mm <= mm_wrap ? 6'd0 : mm + 6'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      hh <= RST_HH;
    else if (hh_carry || (edit_en && tk.inc_hour))
      hh <= hh_wrap ? 5'd0 : hh + 5'd1;
  end

  // 3600 = 2048+1024+512+16, 60 = 32+16+8+4
  assign hh_x    = 17'(hh);
  assign mm_x    = 17'(mm);
  assign hh_secs = (hh_x << 11) + (hh_x << 10) + (hh_x << 9) + (hh_x << 4);
  assign mm_secs = (mm_x << 5) + (mm_x << 4) + (mm_x << 3) + (mm_x << 2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tk.disp_time <= RST_DISP;
      tk.sec_tick  <= 1'b0;
      tk.day_wrap  <= 1'b0;
    end else begin
      tk.disp_time <= hh_secs + mm_secs + 17'(ss);
      tk.sec_tick  <= tick_en;
      tk.day_wrap  <= hh_carry && hh_wrap;
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper: a seconds-since-midnight model
// predicts each cycle's outputs; a negedge monitor compares them.
module tb_time_keeper;

  localparam int TPS = 4;
  localparam int RT  = 86398;

  logic clk = 1'b0;
  logic reset = 1'b1;

  time_keeper_if tk ();

  time_keeper #(
    .TICKS_PER_SEC(TPS),
    .RESET_TIME(RT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tk(tk)
  );

  always #5 clk = ~clk;

  typedef struct {
    int disp;
    bit tick;
    bit wrap;
  } exp_t;

  exp_t q[$];
  exp_t me;

  int t;
  int cnt;
  bit in_set;
  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: time as one integer, cycles counted since the last second.
  task automatic apply(bit sm, bit ih, bit im, bit rs);
    exp_t e;
    int m;
    if (rs) begin
      t = RT;
      cnt = 0;
      in_set = 0;
      e = '{RT, 1'b0, 1'b0};
    end else begin
      e = '{t, 1'b0, 1'b0};
      if (!in_set) begin
        if (sm) begin
          in_set = 1;
          t = t - (t % 60);
          cnt = 0;
        end else begin
          cnt++;
          if (cnt == TPS) begin
            cnt = 0;
            t = (t + 1) % 86400;
            e.tick = 1'b1;
            e.wrap = (t == 0);
          end
        end
      end else begin
        if (ih) t = (t + 3600) % 86400;
        if (im) begin
          m = (t / 60) % 60;
          t = t - m * 60 + ((m + 1) % 60) * 60;
        end
        if (!sm) begin
          in_set = 0;
          cnt = 0;
        end
      end
    end
    q.push_back(e);
  endtask

  task automatic step(bit sm, bit ih, bit im, bit rs);
    @(negedge clk);
    tk.set_mode = sm;
    tk.inc_hour = ih;
    tk.inc_min = im;
    reset = rs;
    @(posedge clk);
    apply(sm, ih, im, rs);
  endtask

  task automatic set_to(int h, int mi);
    int nh;
    int nm;
    nh = (h - t / 3600 + 24) % 24;
    repeat (nh) step(1, 1, 0, 0);
    nm = (mi - (t / 60) % 60 + 60) % 60;
    repeat (nm) step(1, 0, 1, 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      check("disp_time", 32'(tk.disp_time), me.disp);
      check("sec_tick", 32'(tk.sec_tick), 32'(me.tick));
      check("day_wrap", 32'(tk.day_wrap), 32'(me.wrap));
    end
  end

  initial begin
    bit sm;
    tk.set_mode = 1'b0;
    tk.inc_hour = 1'b0;
    tk.inc_min = 1'b0;
    t = RT;
    cnt = 0;
    in_set = 0;

    repeat (3) step(0, 0, 0, 1);

    // Free run across midnight; buttons must be ignored in RUN.
    repeat (40) step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

    // Reach 00:59:59, then SET clears seconds and minute wraps alone.
    step(1, 0, 0, 0);
    set_to(0, 59);
    step(0, 0, 0, 0);
    repeat (59 * TPS) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    repeat (24) step(1, 1, 0, 0);

    // 10:20:00 then both buttons at once, then a long frozen SET.
    set_to(10, 20);
    step(1, 1, 1, 0);
    repeat (50) step(1, 0, 0, 0);

    // Re-enter SET at every prescaler phase, including terminal count.
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0, 0);
      repeat (k) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0);

    sm = 1'b0;
    repeat (400) begin
      if ($urandom_range(0, 9) == 0) sm = ~sm;
      step(sm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    // Asynchronous reset while in SET at 12:34:00.
    step(1, 0, 0, 0);
    set_to(12, 34);
    step(1, 0, 0, 0);
    check("model_at_1234", t, 45240);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("async_disp", 32'(tk.disp_time), RT);
    check("async_tick", 32'(tk.sec_tick), 0);
    check("async_wrap", 32'(tk.day_wrap), 0);
    @(posedge clk);
    apply(1, 0, 0, 1);
    step(1, 0, 0, 1);
    repeat (20) step(0, 0, 0, 0);

    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Time-of-day source for the alarm clock. Produces the 17-bit `disp_time` word that drives the seven-segment display controller.
- `disp_time` encoding is fixed: binary seconds since midnight, range 0..86399.
- Contains a one-second prescaler, separate hour/minute/second counters, and a RUN/SET mode machine.
- Buttons enter the block as already-debounced single-cycle pulses.

Parameters:
- TICKS_PER_SEC, 100000000, clk cycles per second; must be >= 2.
- RESET_TIME, 0, disp_time value loaded at reset (0..86399).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- set_mode  input  1  level; 1 = SET state, time frozen and editable
- inc_hour  input  1  single-cycle pulse; advance hour field (valid in SET only)
- inc_min  input  1  single-cycle pulse; advance minute field (valid in SET only)
- disp_time  output  17  registered seconds since midnight, 0..86399
- sec_tick  output  1  one-cycle pulse each counted second (RUN only)
- day_wrap  output  1  one-cycle pulse when time wraps 23:59:59 -> 00:00:00

Behaviour:
- Internal state:
  - presc: counts 0..TICKS_PER_SEC-1.
  - hh 0..23, mm 0..59, ss 0..59.
  - state in {RUN, SET}.
- Reset (async, takes effect immediately and has priority over everything):
  - presc = 0, state = RUN.
  - hh/mm/ss = RESET_TIME decomposed.
  - disp_time = RESET_TIME, sec_tick = 0, day_wrap = 0.
- RUN state:
  - presc increments each cycle.
  - At presc == TICKS_PER_SEC-1: presc -> 0, second advances, sec_tick = 1 for exactly that cycle.
  - Second advance: ss 59 -> 0 carries to mm; mm 59 -> 0 carries to hh; hh 23 -> 0 with day_wrap = 1 in the same cycle as sec_tick.
  - inc_hour / inc_min are ignored.
- RUN -> SET when set_mode == 1, sampled at a clock edge. On the transition edge:
  - ss <= 0 and presc <= 0.
  - No tick is counted on that edge, even if presc was at terminal count.
- SET state:
  - presc held at 0; sec_tick = 0 and day_wrap = 0 throughout.
  - inc_hour: hh = (hh+1) mod 24; mm and ss untouched.
  - inc_min: mm = (mm+1) mod 60; no carry into hh.
  - Simultaneous inc_hour and inc_min in one cycle: both applied on that edge.
  - A pulse held high for N cycles counts N increments; debouncing is upstream.
- SET -> RUN when set_mode == 0. presc restarts from 0, so the first sec_tick comes TICKS_PER_SEC cycles after the first RUN cycle.
- disp_time:
  - Registered as hh*3600 + mm*60 + ss, one cycle after the counter update. Latency: counter change at edge k appears on disp_time at edge k+1.
  - Never exceeds 86399.
  - Multiply by constants via shift-add; width is 17 bits with no truncation.
- sec_tick and day_wrap are registered and aligned with the counter-update edge, not with disp_time; they lead disp_time by one cycle.
- Reset mid-operation (mid-count or in SET) forces the reset values listed above on the next evaluation, with no partial update.

Test Plan:
1. TICKS_PER_SEC=4, RESET_TIME=0:
   - Release reset, run 12 cycles.
   - Required: sec_tick on cycles 4, 8, 12; disp_time 1, 2, 3, each appearing one cycle after its tick; day_wrap never asserted.
2. RESET_TIME=86398, TICKS_PER_SEC=4:
   - Run 8 cycles.
   - Required: disp_time goes 86399, then 0; day_wrap high for exactly one cycle, coincident with the second sec_tick.
3. RESET_TIME=3599 (00:59:59):
   - Enter SET.
   - Required: disp_time becomes 3540 (ss cleared).
   - Pulse inc_min once. Required: disp_time 0 (mm wraps 59 -> 0, hh stays 0).
   - Pulse inc_hour 24 times. Required: disp_time returns to 0.
4. In SET with time 10:20:00 (37200):
   - Assert inc_hour and inc_min in the same cycle.
   - Required: disp_time 40860 (11:21:00).
   - Hold set_mode for 50 cycles. Required: no sec_tick.
5. Leave SET, TICKS_PER_SEC=4:
   - Required: first sec_tick exactly 4 cycles after set_mode falls.
   - Enter SET while presc == 3. Required: no tick counted on that edge.
6. Assert reset asynchronously between clock edges while in SET at 12:34:00.
   - Required: disp_time = RESET_TIME, state RUN, sec_tick = 0 and day_wrap = 0, all immediately and before the next clk edge.
